clint_mh_apb: RTL and testbench

//  Multi-hart Core-Local Interruptor on APB: one shared 64-bit MTIME, per-hart MSIP and MTIMECMP.
//  Per-hart machine software/timer interrupts go to each hart's interrupt logic.

---
 rtl/clint_mh_apb_if.sv | 30 +++
 rtl/clint_mh_apb.sv | 182 ++++++++++++++++++
 tb/tb_clint_mh_apb.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_mh_apb_if.sv
// APB slave bus bundle for the multi-hart CLINT.
// Signals:
//   PSEL, PENABLE, PWRITE  transfer control (master -> slave)
//   PADDR [15:0]           byte address within the CLINT
//   PWDATA, PSTRB          write data and byte-lane strobes (master -> slave)
//   PRDATA                 read data (slave -> master)
//   PREADY, PSLVERR        completion and error response (slave -> master)
interface clint_mh_apb_if #(
  parameter int unsigned XLEN = 64
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [15:0]       PADDR;
  logic [XLEN-1:0]   PWDATA;
  logic [XLEN/8-1:0] PSTRB;
  logic [XLEN-1:0]   PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/clint_mh_apb.sv
// Multi-hart Core-Local Interruptor on APB.
// One shared 64-bit MTIME advanced by a tick prescaler, plus per-hart MSIP and MTIMECMP.
// Ports:
//   PCLK       APB/timer clock
//   PRESETn    asynchronous active-low reset
//   apb        APB slave bus (zero wait states, PSLVERR on unmapped access)
//   MTIME      current time
//   MSwInt     per-hart machine software interrupt (MSIP bit)
//   MTimerInt  per-hart machine timer interrupt (MTIME >= MTIMECMP)
// Map: 0x0000+4h MSIP[h], 0x4000+8h MTIMECMP[h], 0xBFF8 MTIME (+4 high half on XLEN=32).
module clint_mh_apb #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NHARTS  = 1,
  parameter int unsigned TICKDIV = 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  clint_mh_apb_if.slave     apb,
  output logic [63:0]       MTIME,
  output logic [NHARTS-1:0] MSwInt,
  output logic [NHARTS-1:0] MTimerInt
);
  localparam int unsigned NB        = XLEN / 8;
  localparam bit          IS32      = (XLEN == 32);
  localparam logic [15:0] PRESC_MAX = 16'(TICKDIV - 1);

  logic [63:0]       mtime_q, mtime_d;
  logic [15:0]       presc_q, presc_d;
  logic [NHARTS-1:0] msip_q, msip_d;
  logic [63:0]       mtimecmp_q [NHARTS];
  logic [63:0]       mtimecmp_d [NHARTS];
  logic [XLEN-1:0]   prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;
  logic [31:0]       snap_q, snap_d;
  logic              snap_vld_q, snap_vld_d;

  // Address decode. MSIP slots are 4 bytes apart on either bus width, so the hart index
  // comes from PADDR[5:2]; on XLEN=64 only the low word of the bus carries the MSIP bit.
  logic [3:0] msip_idx, cmp_idx;
  logic       hit_msip, hit_cmp, hit_time, half_hi;
  logic [5:0] rshift;
  logic       setup, acc_wr, tick;
  logic       unused_paddr;

  assign msip_idx     = apb.PADDR[5:2];
  assign cmp_idx      = apb.PADDR[6:3];
  assign hit_msip     = (apb.PADDR[15:6] == 10'h000) && (32'(msip_idx) < NHARTS);
  assign hit_cmp      = (apb.PADDR[15:7] == 9'h080) && (32'(cmp_idx) < NHARTS);
  assign hit_time     = (apb.PADDR[15:3] == 13'h17FF);
  assign half_hi      = IS32 & apb.PADDR[2];
  assign rshift       = {half_hi, 5'b00000};
  assign setup        = apb.PSEL & ~apb.PENABLE;
  assign acc_wr       = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign tick         = (presc_q == PRESC_MAX);
  assign unused_paddr = ^apb.PADDR[1:0];

  // Byte strobes expanded to a bit mask and placed on the addressed 32-bit half.
  logic [XLEN-1:0] strb_bits;
  logic [63:0]     wmask, wdat;

  always_comb begin
    strb_bits = '0;
    for (int i = 0; i < NB; i++) begin
      strb_bits[i*8 +: 8] = {8{apb.PSTRB[i]}};
    end
  end

  assign wmask = 64'(strb_bits) << rshift;
  assign wdat  = 64'(apb.PWDATA) << rshift;

  // Read mux over the currently addressed register.
  logic            msip_sel;
  logic [63:0]     cmp_sel;
  logic [XLEN-1:0] rd_word;

  always_comb begin
    msip_sel = 1'b0;
    cmp_sel  = '0;
    for (int h = 0; h < NHARTS; h++) begin
      if (msip_idx == 4'(h)) msip_sel = msip_q[h];
      if (cmp_idx == 4'(h))  cmp_sel  = mtimecmp_q[h];
    end
  end

  always_comb begin
    rd_word = '0;
    if (hit_msip) begin
      rd_word = XLEN'(msip_sel);
    end else if (hit_cmp) begin
      rd_word = XLEN'(cmp_sel >> rshift);
    end else if (hit_time) begin
      if (half_hi && snap_vld_q) rd_word = XLEN'(snap_q);
      else                       rd_word = XLEN'(mtime_q >> rshift);
    end
  end

  always_comb begin
    mtime_d    = mtime_q;
    presc_d    = presc_q;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    prdata_d   = prdata_q;
    pslverr_d  = pslverr_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;

    // A bus write wins over the tick and restarts the prescaler; unwritten lanes hold.
    if (acc_wr && hit_time) begin
      mtime_d = (mtime_q & ~wmask) | (wdat & wmask);
      presc_d = '0;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + 16'd1;
    end

    for (int h = 0; h < NHARTS; h++) begin
      if (acc_wr && hit_msip && (msip_idx == 4'(h)) && apb.PSTRB[0]) begin
        msip_d[h] = apb.PWDATA[0];
      end
      if (acc_wr && hit_cmp && (cmp_idx == 4'(h))) begin
        mtimecmp_d[h] = (mtimecmp_q[h] & ~wmask) | (wdat & wmask);
      end
    end

    // Response is captured on the setup-phase edge and held through the access phase.
    if (setup) begin
      prdata_d  = apb.PWRITE ? '0 : rd_word;
      pslverr_d = ~(hit_msip | hit_cmp | hit_time);
    end

    // Reading the low MTIME word freezes the high word so the following high read
    // pairs with it even if a carry happens in between.
    if (IS32) begin
      if (setup && !apb.PWRITE && hit_time) begin
        if (!half_hi) begin
          snap_d     = mtime_q[63:32];
          snap_vld_d = 1'b1;
        end else begin
          snap_vld_d = 1'b0;
        end
      end
      if (acc_wr && hit_time) snap_vld_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mtime_q    <= '0;
      presc_q    <= '0;
      msip_q     <= '0;
      for (int h = 0; h < NHARTS; h++) mtimecmp_q[h] <= '1;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      presc_q    <= presc_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
    end
  end

  always_comb begin
    MTimerInt = '0;
    for (int h = 0; h < NHARTS; h++) begin
      MTimerInt[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  assign MTIME       = mtime_q;
  assign MSwInt      = msip_q;
  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = pslverr_q & apb.PSEL & apb.PENABLE;
endmodule

// File: tb/tb_clint_mh_apb.sv
// Bench for clint_mh_apb: DUT A (XLEN=64, 2 harts, TICKDIV=4) and DUT B (XLEN=32, 2 harts,
// TICKDIV=1). APB transfers push their expected response into a queue; a monitor pops and
// compares in every access phase. Time and interrupt outputs are checked inline.
module tb_clint_mh_apb;
  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  clint_mh_apb_if #(.XLEN(64)) bus_a ();
  clint_mh_apb_if #(.XLEN(32)) bus_b ();

  logic [63:0] mtime_a, mtime_b;
  logic [1:0]  msw_a, msw_b, mti_a, mti_b;

  clint_mh_apb #(.XLEN(64), .NHARTS(2), .TICKDIV(4)) dut_a (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .apb       (bus_a),
    .MTIME     (mtime_a),
    .MSwInt    (msw_a),
    .MTimerInt (mti_a)
  );

  clint_mh_apb #(.XLEN(32), .NHARTS(2), .TICKDIV(1)) dut_b (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .apb       (bus_b),
    .MTIME     (mtime_b),
    .MSwInt    (msw_b),
    .MTimerInt (mti_b)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic        chk_rd;
    logic        err;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    n_checks = 0;
  int    n_errors = 0;

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;
  localparam bit RD = 1'b0;
  localparam bit WR = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the access-phase edge.
  task automatic xfer(input bit b, input bit wr, input logic [15:0] addr,
                      input logic [63:0] wd, input logic [7:0] strb, input bit chk_rd,
                      input logic [63:0] exp_rd, input bit exp_err, input string nm);
    exp_t e;
    e.rdata  = exp_rd;
    e.chk_rd = chk_rd;
    e.err    = exp_err;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (b == A) begin
      bus_a.PSEL = 1'b1; bus_a.PENABLE = 1'b0; bus_a.PWRITE = wr;
      bus_a.PADDR = addr; bus_a.PWDATA = wd; bus_a.PSTRB = strb;
    end else begin
      bus_b.PSEL = 1'b1; bus_b.PENABLE = 1'b0; bus_b.PWRITE = wr;
      bus_b.PADDR = addr; bus_b.PWDATA = wd[31:0]; bus_b.PSTRB = strb[3:0];
    end
    @(posedge PCLK); #1;
    if (b == A) bus_a.PENABLE = 1'b1;
    else        bus_b.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    bus_a.PSEL = 1'b0; bus_a.PENABLE = 1'b0; bus_a.PWRITE = 1'b0;
    bus_b.PSEL = 1'b0; bus_b.PENABLE = 1'b0; bus_b.PWRITE = 1'b0;
  endtask

  task automatic rd(input bit b, input logic [15:0] addr, input logic [63:0] exp_rd,
                    input bit exp_err, input string nm);
    xfer(b, RD, addr, 64'h0, 8'h00, 1'b1, exp_rd, exp_err, nm);
  endtask

  task automatic wr(input bit b, input logic [15:0] addr, input logic [63:0] wd,
                    input logic [7:0] strb, input bit exp_err, input string nm);
    xfer(b, WR, addr, wd, strb, 1'b0, 64'h0, exp_err, nm);
  endtask

  task automatic sync();
    @(posedge PCLK); #1;
  endtask

  // Scoreboard monitor: compares each access-phase response against the queue head.
  always @(negedge PCLK) begin : mon
    logic [63:0] act_rd;
    logic        act_err;
    exp_t        e;
    string       nm;
    if ((bus_a.PSEL && bus_a.PENABLE) || (bus_b.PSEL && bus_b.PENABLE)) begin
      if (bus_a.PSEL && bus_a.PENABLE) begin
        act_rd  = bus_a.PRDATA;
        act_err = bus_a.PSLVERR;
      end else begin
        act_rd  = 64'(bus_b.PRDATA);
        act_err = bus_b.PSLVERR;
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_access: got rdata %h with no expected entry", act_rd);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, ".pslverr"}, 64'(act_err), 64'(e.err));
        if (e.chk_rd) chk({nm, ".prdata"}, act_rd, e.rdata);
      end
    end
  end

  initial begin
    int seen;
    bus_a.PSEL = 1'b0; bus_a.PENABLE = 1'b0; bus_a.PWRITE = 1'b0;
    bus_a.PADDR = '0;  bus_a.PWDATA = '0;    bus_a.PSTRB = '0;
    bus_b.PSEL = 1'b0; bus_b.PENABLE = 1'b0; bus_b.PWRITE = 1'b0;
    bus_b.PADDR = '0;  bus_b.PWDATA = '0;    bus_b.PSTRB = '0;
    PRESETn = 1'b1;
    #2 PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_mtime_a", mtime_a, 64'h0);
    chk("rst_mtime_b", mtime_b, 64'h0);
    chk("rst_mti", {60'h0, mti_a, mti_b}, 64'h0);
    chk("rst_msw", {60'h0, msw_a, msw_b}, 64'h0);
    chk("rst_prdata_a", bus_a.PRDATA, 64'h0);
    chk("rst_pready_a", 64'(bus_a.PREADY), 64'h1);
    PRESETn = 1'b1;

    // Counting after reset: B every edge, A every 4th edge.
    for (int k = 0; k < 8; k++) begin
      @(negedge PCLK);
      chk($sformatf("count_b_%0d", k), mtime_b, 64'(k));
      chk($sformatf("count_a_%0d", k), mtime_a, 64'(k / 4));
    end
    chk("mti_after_reset", {60'h0, mti_a, mti_b}, 64'h0);
    sync();

    rd(A, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "cmp0_rst_a");
    rd(A, 16'h4008, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "cmp1_rst_a");
    rd(B, 16'h4000, 64'hFFFF_FFFF, 1'b0, "cmp0_lo_rst_b");
    rd(B, 16'h4004, 64'hFFFF_FFFF, 1'b0, "cmp0_hi_rst_b");

    // MTIME write restarts the prescaler: 101 appears exactly 4 edges later.
    wr(A, 16'hBFF8, 64'd100, 8'hFF, 1'b0, "mtime_wr_a");
    for (int k = 0; k <= 4; k++) begin
      @(negedge PCLK);
      chk($sformatf("presc_step_%0d", k), mtime_a, (k == 4) ? 64'd101 : 64'd100);
    end
    sync();

    // Timer interrupt on hart 1 only, 10 ticks (40 cycles) after MTIME=1000.
    wr(A, 16'h4008, 64'd1010, 8'hFF, 1'b0, "cmp1_wr_a");
    wr(A, 16'hBFF8, 64'd1000, 8'hFF, 1'b0, "mtime_1000_a");
    seen = -1;
    for (int i = 0; i <= 60; i++) begin
      @(negedge PCLK);
      chk($sformatf("mti0_low_%0d", i), 64'(mti_a[0]), 64'h0);
      if (mti_a[1] && seen < 0) seen = i;
    end
    chk("mti1_latency", 64'(seen), 64'd40);
    chk("mti_a_final", 64'(mti_a), 64'h2);
    sync();
    wr(A, 16'h0000, 64'h1, 8'h0F, 1'b0, "msip0_wr_a");
    chk("msw_a", 64'(msw_a), 64'h1);
    rd(A, 16'h0000, 64'h1, 1'b0, "msip0_rd_a");
    wr(A, 16'h4008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, "cmp1_raise_a");
    chk("mti_a_deassert", 64'(mti_a), 64'h0);
    wr(B, 16'h0004, 64'h1, 8'h0F, 1'b0, "msip1_wr_b");
    chk("msw_b", 64'(msw_b), 64'h2);
    rd(B, 16'h0004, 64'h1, 1'b0, "msip1_rd_b");
    rd(B, 16'h0000, 64'h0, 1'b0, "msip0_rd_b");

    // Byte strobes.
    wr(A, 16'h4000, 64'h55, 8'h01, 1'b0, "cmp0_byte_a");
    rd(A, 16'h4000, 64'hFFFF_FFFF_FFFF_FF55, 1'b0, "cmp0_byte_rd_a");
    wr(B, 16'h4004, 64'h0000_AB00, 8'h02, 1'b0, "cmp0_hi_byte_b");
    rd(B, 16'h4004, 64'hFFFF_ABFF, 1'b0, "cmp0_hi_byte_rd_b");

    // Torn-read-free MTIME across the 32-bit carry.
    wr(B, 16'hBFFC, 64'h0, 8'h0F, 1'b0, "mtime_hi_wr_b");
    wr(B, 16'hBFF8, 64'hFFFF_FFFE, 8'h0F, 1'b0, "mtime_lo_wr_b");
    rd(B, 16'hBFF8, 64'hFFFF_FFFE, 1'b0, "snap_lo_b");
    rd(B, 16'hBFFC, 64'h0, 1'b0, "snap_hi_b");
    rd(B, 16'hBFFC, 64'h1, 1'b0, "live_hi_b");
    xfer(B, RD, 16'hBFF8, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0, "snap_lo2_b");
    wr(B, 16'hBFFC, 64'h5, 8'h0F, 1'b0, "mtime_hi5_b");
    rd(B, 16'hBFFC, 64'h5, 1'b0, "snap_cleared_b");

    // Map errors.
    rd(B, 16'h0008, 64'h0, 1'b1, "msip2_err_b");
    rd(A, 16'h0008, 64'h0, 1'b1, "msip2_err_a");
    wr(A, 16'h4010, 64'h1234, 8'hFF, 1'b1, "cmp2_wr_err_a");
    rd(A, 16'h4000, 64'hFFFF_FFFF_FFFF_FF55, 1'b0, "cmp0_intact_a");
    rd(A, 16'h4008, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "cmp1_intact_a");
    rd(A, 16'h4010, 64'h0, 1'b1, "cmp2_rd_err_a");
    rd(A, 16'h2000, 64'h0, 1'b1, "hole_err_a");
    wr(B, 16'h4010, 64'h0, 8'h0F, 1'b1, "cmp2_wr_err_b");
    rd(B, 16'h4000, 64'hFFFF_FFFF, 1'b0, "cmp0_lo_intact_b");

    // Reset asserted during an access phase.
    bus_a.PSEL = 1'b1; bus_a.PENABLE = 1'b0; bus_a.PWRITE = 1'b1;
    bus_a.PADDR = 16'h0000; bus_a.PWDATA = 64'h0; bus_a.PSTRB = 8'hFF;
    @(posedge PCLK); #1;
    bus_a.PENABLE = 1'b1;
    #1 PRESETn = 1'b0;
    #1;
    chk("mid_rst_mtime_a", mtime_a, 64'h0);
    chk("mid_rst_mtime_b", mtime_b, 64'h0);
    chk("mid_rst_msw", {60'h0, msw_a, msw_b}, 64'h0);
    chk("mid_rst_mti", {60'h0, mti_a, mti_b}, 64'h0);
    chk("mid_rst_prdata_b", 64'(bus_b.PRDATA), 64'h0);
    chk("mid_rst_pslverr_a", 64'(bus_a.PSLVERR), 64'h0);
    bus_a.PSEL = 1'b0; bus_a.PENABLE = 1'b0; bus_a.PWRITE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    rd(A, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "cmp0_after_rst_a");
    rd(B, 16'h4004, 64'hFFFF_FFFF, 1'b0, "cmp0_hi_after_rst_b");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge PCLK);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
